flow_light_ctrl: RTL

Sequencer for the running-light display: owns a speed-selectable prescaler and steps a one-hot LED pattern once per prescaler tick.
- Modes: rotate left, rotate right, bounce.
- Also provides run/pause/clear control and saturating speed up/down from pulse inputs.
- Sits between the debounced board buttons/switches and the LED outputs. It replaces free-running divided clocks with a single-clock, tick-enabled design.

---
 rtl/flow_light_pkg.sv | 40 ++++
 rtl/flow_tick_gen.sv | 54 +++++
 rtl/flow_light_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/flow_light_pkg.sv
// flow_light_pkg: shared types and constants for the running-light sequencer.
// Optional feature macro used by the sequencer top: FLOW_LAP_CNT_EN.
package flow_light_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Pattern select encodings on the Mode input.
    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Slowest speed index; 0 is the fastest.
    localparam logic [1:0] SP_MAX = 2'd3;

    // Bounce direction encoding.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Terminal count for a speed index: (sp+1)*n in 32 bits, built from
    // shifts and one add so no general multiplier is needed.
    function automatic logic [31:0] period_max(input logic [1:0] sp,
                                               input logic [31:0] n);
        logic [31:0] result;
        case (sp)
            2'd0:    result = n;
            2'd1:    result = {n[30:0], 1'b0};
            2'd2:    result = {n[30:0], 1'b0} + n;
            2'd3:    result = {n[29:0], 2'b00};
            default: result = n;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/flow_tick_gen.sv
// flow_tick_gen: speed-selectable prescaler. Counts 0..MAX while enabled and
// flags a tick in the cycle where the count has reached or passed MAX, so a
// speed increase mid-count can never overrun the terminal value.
module flow_tick_gen
    import flow_light_pkg::*;
#(
    parameter int N = 12500000
) (
    input  logic       CLK_in,
    input  logic       RST_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] Sp,
    output logic       tick
);

    localparam logic [31:0] N_W = 32'(N);

    logic [31:0] count_r;
    logic [31:0] count_next_s;
    logic [31:0] max_s;
    logic        tick_s;

    // Terminal compare and next counter value.
    always_comb begin
        max_s        = period_max(Sp, N_W);
        tick_s       = 1'b0;
        count_next_s = count_r;
        if (clr) begin
            count_next_s = 32'd0;
        end else if (en) begin
            if (count_r >= max_s) begin
                tick_s       = 1'b1;
                count_next_s = 32'd0;
            end else begin
                count_next_s = count_r + 32'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            count_r <= 32'd0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/flow_light_ctrl.sv
// flow_light_ctrl: running-light sequencer. Holds the IDLE/RUN/PAUSE FSM,
// the saturating speed register and the one-hot pattern stepper; the
// prescaler lives in flow_tick_gen.
// Optional feature: define FLOW_LAP_CNT_EN to add the Lap counter output.
module flow_light_ctrl
    import flow_light_pkg::*;
#(
    parameter int N     = 12500000,
    parameter int LED_W = 16
) (
    input  logic             CLK_in,
    input  logic             RST_n,
    input  logic             Run,
    input  logic             Clr,
    input  logic [1:0]       Mode,
    input  logic             Sp_up,
    input  logic             Sp_dn,
    output logic [1:0]       Sp,
    output logic             Tick,
    output logic [LED_W-1:0] LED
`ifdef FLOW_LAP_CNT_EN
    ,
    output logic [7:0]       Lap
`endif
);

    localparam logic [LED_W-1:0] LED_BIT0 = {{(LED_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       sp_r;
    logic [1:0]       sp_next_s;
    logic [LED_W-1:0] led_r;
    logic [LED_W-1:0] led_next_s;
    logic             dir_r;
    logic             dir_next_s;
    logic             step_dir_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_next_s;
    logic             tick_r;
    logic             tick_next_s;
    logic             cnt_en_s;
    logic             cnt_clr_s;
    logic             tick_s;
    logic             step_s;

    // Count only while running with Run held; IDLE and Clr park the counter at 0.
    assign cnt_en_s  = (state_r == RUN) && Run;
    assign cnt_clr_s = Clr || (state_r == IDLE);

    flow_tick_gen #(
        .N(N)
    ) u_tick_gen (
        .CLK_in(CLK_in),
        .RST_n (RST_n),
        .en    (cnt_en_s),
        .clr   (cnt_clr_s),
        .Sp    (sp_r),
        .tick  (tick_s)
    );

    // A pattern step happens on a prescaler tick unless Clr overrides it.
    assign step_s = tick_s && !Clr;

    // FSM next-state: Clr wins over everything, Run level moves between states.
    always_comb begin
        state_next_s = state_r;
        if (Clr) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Run) state_next_s = RUN;
                    else     state_next_s = IDLE;
                end
                RUN: begin
                    if (!Run) state_next_s = PAUSE;
                    else      state_next_s = RUN;
                end
                PAUSE: begin
                    if (Run) state_next_s = RUN;
                    else     state_next_s = PAUSE;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Saturating speed index; simultaneous up and down pulses cancel.
    always_comb begin
        sp_next_s = sp_r;
        if (Sp_up && !Sp_dn) begin
            if (sp_r != 2'd0) sp_next_s = sp_r - 2'd1;
            else              sp_next_s = sp_r;
        end else if (Sp_dn && !Sp_up) begin
            if (sp_r != SP_MAX) sp_next_s = sp_r + 2'd1;
            else                sp_next_s = sp_r;
        end else begin
            sp_next_s = sp_r;
        end
    end

    // Pattern stepper: LED, bounce direction, sampled mode and Tick pulse.
    always_comb begin
        led_next_s  = led_r;
        dir_next_s  = dir_r;
        mode_next_s = mode_r;
        tick_next_s = 1'b0;
        step_dir_s  = dir_r;
        if (Clr) begin
            led_next_s  = '0;
            dir_next_s  = DIR_LEFT;
            mode_next_s = MODE_ROT_L;
        end else if (state_r == IDLE) begin
            mode_next_s = MODE_ROT_L;
            dir_next_s  = DIR_LEFT;
            if (Run) led_next_s = LED_BIT0;
            else     led_next_s = '0;
        end else if (step_s) begin
            tick_next_s = 1'b1;
            mode_next_s = Mode;
            case (Mode)
                MODE_ROT_L: led_next_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
                MODE_ROT_R: led_next_s = {led_r[0], led_r[LED_W-1:1]};
                MODE_BOUNCE: begin
                    // Entering bounce picks its direction from the previous mode.
                    if (mode_r == MODE_BOUNCE)     step_dir_s = dir_r;
                    else if (mode_r == MODE_ROT_R) step_dir_s = DIR_RIGHT;
                    else                           step_dir_s = DIR_LEFT;
                    // Turn around at an endpoint so it is lit only once.
                    if ((step_dir_s == DIR_LEFT) && led_r[LED_W-1])
                        step_dir_s = DIR_RIGHT;
                    else if ((step_dir_s == DIR_RIGHT) && led_r[0])
                        step_dir_s = DIR_LEFT;
                    else
                        step_dir_s = step_dir_s;
                    if (step_dir_s == DIR_LEFT) led_next_s = {led_r[LED_W-2:0], 1'b0};
                    else                        led_next_s = {1'b0, led_r[LED_W-1:1]};
                    dir_next_s = step_dir_s;
                end
                MODE_HOLD: led_next_s = led_r;
                default:   led_next_s = led_r;
            endcase
        end else begin
            led_next_s = led_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Speed and pattern registers; all outputs come straight from these.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            sp_r   <= 2'd0;
            led_r  <= '0;
            dir_r  <= DIR_LEFT;
            mode_r <= MODE_ROT_L;
            tick_r <= 1'b0;
        end else begin
            sp_r   <= sp_next_s;
            led_r  <= led_next_s;
            dir_r  <= dir_next_s;
            mode_r <= mode_next_s;
            tick_r <= tick_next_s;
        end
    end

    assign Sp   = sp_r;
    assign Tick = tick_r;
    assign LED  = led_r;

`ifdef FLOW_LAP_CNT_EN
    logic [7:0] lap_r;
    logic [7:0] lap_next_s;

    // A lap completes whenever a step lands the light on bit 0 from elsewhere.
    always_comb begin
        lap_next_s = lap_r;
        if (Clr) begin
            lap_next_s = 8'd0;
        end else if (step_s && (state_r != IDLE) && led_next_s[0] && !led_r[0]) begin
            lap_next_s = lap_r + 8'd1;
        end else begin
            lap_next_s = lap_r;
        end
    end

    // Lap counter register.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            lap_r <= 8'd0;
        end else begin
            lap_r <= lap_next_s;
        end
    end

    assign Lap = lap_r;
`endif

endmodule
